// File: rtl/seg_frame_receiver.sv
// Captures 4-digit BCD frames from a one-hot position strobe and drives a
// multiplexed, active-low 4-digit 7-segment display from the last complete frame.
module seg_frame_receiver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_LZ    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] C_Digit,
    input  logic [3:0] C_7Seg,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_valid,
    output logic       frame_err
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP4 = 2'd1,
        EXP2 = 2'd2,
        EXP1 = 2'd3
    } state_t;

    state_t           state;
    logic [3:0]       shadow3;
    logic [3:0]       shadow2;
    logic [3:0]       shadow1;
    logic [15:0]      disp;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;

    logic             tick_c;
    logic [3:0]       digit_c;
    logic             blank_c;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    // Frame capture: shadows fill as positions arrive, disp loads only on a full 8-4-2-1 run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            shadow3     <= 4'h0;
            shadow2     <= 4'h0;
            shadow1     <= 4'h0;
            disp        <= 16'h0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (C_7Seg == 4'h8) begin
                        shadow3 <= C_Digit;
                        state   <= EXP4;
                    end else if (C_7Seg != 4'h0) begin
                        frame_err <= 1'b1;
                    end
                end
                EXP4, EXP2, EXP1: begin
                    if (state == EXP4 && C_7Seg == 4'h4) begin
                        shadow2 <= C_Digit;
                        state   <= EXP2;
                    end else if (state == EXP2 && C_7Seg == 4'h2) begin
                        shadow1 <= C_Digit;
                        state   <= EXP1;
                    end else if (state == EXP1 && C_7Seg == 4'h1) begin
                        disp        <= {shadow3, shadow2, shadow1, C_Digit};
                        frame_valid <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        // Out-of-sequence code aborts; a fresh MSD restarts the frame.
                        frame_err <= 1'b1;
                        if (C_7Seg == 4'h8) begin
                            shadow3 <= C_Digit;
                            state   <= EXP4;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tick_c  = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign digit_c = disp[{idx, 2'b00} +: 4];
    // Leading zero: this digit and every more-significant digit are zero.
    assign blank_c = (BLANK_LZ != 0) && (idx != 2'd0) && ((disp >> {idx, 2'b00}) == 16'h0);

    // Display scan: prescaler paces idx, outputs re-registered every cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            idx <= 2'd0;
            an  <= 4'hF;
            seg <= 7'h7F;
        end else begin
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
            if (tick_c) begin
                idx <= idx + 2'd1;
            end
            an  <= ~(4'b0001 << idx);
            seg <= blank_c ? 7'h7F : seg_decode(digit_c);
        end
    end

endmodule

// File: tb/tb_seg_frame_receiver.sv
// Directed bench for seg_frame_receiver: pulse expectations go through a queue,
// display contents are checked against a decode model over full scan periods.
module tb_seg_frame_receiver;

    logic       clk;
    logic       rst;
    logic [3:0] C_Digit;
    logic [3:0] C_7Seg;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_valid;
    logic       frame_err;
    logic [3:0] an_lz;
    logic [6:0] seg_lz;
    logic       frame_valid_lz;
    logic       frame_err_lz;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic v;
        logic e;
    } pulse_t;

    pulse_t exp_q[$];

    seg_frame_receiver #(.REFRESH_DIV(4), .BLANK_LZ(0)) dut (
        .clk(clk), .rst(rst), .C_Digit(C_Digit), .C_7Seg(C_7Seg),
        .an(an), .seg(seg), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    seg_frame_receiver #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .rst(rst), .C_Digit(C_Digit), .C_7Seg(C_7Seg),
        .an(an_lz), .seg(seg_lz), .frame_valid(frame_valid_lz), .frame_err(frame_err_lz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_model(input logic [3:0] v);
        logic [6:0] t;
        case (v)
            4'd0: t = 7'h40;  4'd1: t = 7'h79;  4'd2: t = 7'h24;  4'd3: t = 7'h30;
            4'd4: t = 7'h19;  4'd5: t = 7'h12;  4'd6: t = 7'h02;  4'd7: t = 7'h78;
            4'd8: t = 7'h00;  4'd9: t = 7'h10;
            default: t = 7'h7F;
        endcase
        return t;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] d, input int pos, input bit lz);
        logic [3:0] dig [4];
        bit         blank;
        for (int k = 0; k < 4; k++) dig[k] = d[k*4 +: 4];
        blank = lz && (pos != 0);
        for (int k = pos; k < 4; k++) begin
            if (dig[k] != 4'h0) blank = 1'b0;
        end
        return blank ? 7'h7F : seg_model(dig[pos]);
    endfunction

    function automatic int pos_of(input logic [3:0] a);
        case (a)
            4'hE:    return 0;
            4'hD:    return 1;
            4'hB:    return 2;
            4'h7:    return 3;
            default: return -1;
        endcase
    endfunction

    // One sender cycle; expected pulses for this sample are queued, then popped after the edge.
    task automatic drive(input logic [3:0] code, input logic [3:0] dig, input logic v, input logic e);
        pulse_t p;
        @(negedge clk);
        C_7Seg  = code;
        C_Digit = dig;
        exp_q.push_back('{v: v, e: e});
        @(posedge clk);
        #1;
        p = exp_q.pop_front();
        chk("frame_valid", 16'(frame_valid), 16'(p.v));
        chk("frame_err", 16'(frame_err), 16'(p.e));
        chk("frame_valid_lz", 16'(frame_valid_lz), 16'(p.v));
        chk("frame_err_lz", 16'(frame_err_lz), 16'(p.e));
    endtask

    task automatic frame(input logic [15:0] d);
        drive(4'h8, d[15:12], 1'b0, 1'b0);
        drive(4'h4, d[11:8], 1'b0, 1'b0);
        drive(4'h2, d[7:4], 1'b0, 1'b0);
        drive(4'h1, d[3:0], 1'b1, 1'b0);
    endtask

    // One full scan period (4 positions x 4 cycles) checked against disp value d.
    task automatic scan(input logic [15:0] d, input string tag);
        int         cnt [4];
        int         p;
        int         pl;
        logic [3:0] prev;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        prev = an;
        for (int c = 0; c < 16; c++) begin
            drive(4'h0, 4'h0, 1'b0, 1'b0);
            p  = pos_of(an);
            pl = pos_of(an_lz);
            chk({tag, " an_valid"}, 16'(p >= 0), 16'(1));
            chk({tag, " an_lz_valid"}, 16'(pl >= 0), 16'(1));
            if (an != prev) chk({tag, " an_rotate"}, 16'(an), 16'({prev[2:0], prev[3]}));
            prev = an;
            if (p >= 0) begin
                chk({tag, " seg"}, 16'(seg), 16'(exp_seg(d, p, 1'b0)));
                cnt[p]++;
            end
            if (pl >= 0) chk({tag, " seg_lz"}, 16'(seg_lz), 16'(exp_seg(d, pl, 1'b1)));
        end
        for (int k = 0; k < 4; k++) chk({tag, " an_dwell"}, 16'(cnt[k]), 16'(4));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        C_7Seg  = 4'h0;
        C_Digit = 4'h0;
        @(posedge clk);
        #1;
        chk("rst an", 16'(an), 16'(4'hF));
        chk("rst seg", 16'(seg), 16'(7'h7F));
        chk("rst valid", 16'(frame_valid), 16'(0));
        chk("rst err", 16'(frame_err), 16'(0));
        chk("rst an_lz", 16'(an_lz), 16'(4'hF));
        chk("rst seg_lz", 16'(seg_lz), 16'(7'h7F));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release an", 16'(an), 16'(4'hE));
        chk("release seg", 16'(seg), 16'(7'h40));
        chk("release an_lz", 16'(an_lz), 16'(4'hE));
        chk("release seg_lz", 16'(seg_lz), 16'(7'h40));
        chk("release valid", 16'(frame_valid), 16'(0));
        chk("release err", 16'(frame_err), 16'(0));
    endtask

    initial begin
        rst     = 1'b0;
        C_7Seg  = 4'h0;
        C_Digit = 4'h0;
        do_reset();
        scan(16'h0000, "reset");

        // Clean frame
        frame(16'h1234);
        scan(16'h1234, "f1234");

        // Abort on 0, then stray 2 and 1 in IDLE
        drive(4'h8, 4'h5, 1'b0, 1'b0);
        drive(4'h4, 4'h6, 1'b0, 1'b0);
        drive(4'h0, 4'h0, 1'b0, 1'b1);
        drive(4'h2, 4'h7, 1'b0, 1'b1);
        drive(4'h1, 4'h8, 1'b0, 1'b1);
        scan(16'h1234, "abort");

        // Restart on a second 8
        drive(4'h8, 4'h1, 1'b0, 1'b0);
        drive(4'h4, 4'h2, 1'b0, 1'b0);
        drive(4'h8, 4'h9, 1'b0, 1'b1);
        drive(4'h4, 4'h8, 1'b0, 1'b0);
        drive(4'h2, 4'h7, 1'b0, 1'b0);
        drive(4'h1, 4'h6, 1'b1, 1'b0);
        scan(16'h9876, "restart");

        // Non-one-hot code mid-frame
        drive(4'h8, 4'h3, 1'b0, 1'b0);
        drive(4'h6, 4'h3, 1'b0, 1'b1);
        scan(16'h9876, "nonhot");

        // Leading-zero blanking boundaries
        frame(16'h0007);
        scan(16'h0007, "lz0007");
        frame(16'h0000);
        scan(16'h0000, "lz0000");
        frame(16'h0503);
        scan(16'h0503, "lz0503");

        // Hex digit blanks its own position only
        frame(16'h1A34);
        scan(16'h1A34, "hexA");

        // Reset in EXP2 discards shadows and clears disp
        drive(4'h8, 4'h1, 1'b0, 1'b0);
        drive(4'h4, 4'h2, 1'b0, 1'b0);
        do_reset();
        drive(4'h1, 4'h3, 1'b0, 1'b1);
        scan(16'h0000, "midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_frame_receiver.md
SEG_FRAME_RECEIVER -- requirements
Module: seg_frame_receiver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles per display scan step (legal range 2..65535).
REQ-002 SHALL have parameter BLANK_LZ, default 0, meaning that when 1, leading-zero blanking is enabled.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; it is synchronous and active-low (rst=0 resets on the next clk edge).
REQ-005 SHALL have port C_Digit, input, 4, BCD value of the digit currently being sent.
REQ-006 SHALL have port C_7Seg, input, 4, one-hot digit position: 8=pos3 (MSD), 4=pos2, 2=pos1, 1=pos0 (LSD), 0=no digit.
REQ-007 SHALL have port an, output, 4, active-low anode enables; an[i] drives position i.
REQ-008 SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}, with seg[0]=a.
REQ-009 SHALL have port frame_valid, output, 1, a one-cycle pulse marking a committed frame.
REQ-010 SHALL have port frame_err, output, 1, a one-cycle pulse marking a protocol violation.

Function
REQ-011 Sender protocol SHALL be: one cycle each of C_7Seg=8,4,2,1 on consecutive cycles, with C_Digit valid in the same cycle; C_7Seg=0 between frames.
REQ-012 Capture FSM SHALL have states IDLE, EXP4, EXP2, EXP1; C_7Seg/C_Digit are sampled every clk.
REQ-013 IDLE: on 8, SHALL store shadow3=C_Digit and go to EXP4; on 0, SHALL stay; on any other code, SHALL pulse frame_err and stay.
REQ-014 EXP4: on 4, SHALL store shadow2 and go to EXP2. EXP2: on 2, SHALL store shadow1 and go to EXP1.
REQ-015 EXP1: on 1, SHALL load disp={shadow3,shadow2,shadow1,C_Digit} on that edge, pulse frame_valid next cycle, and go to IDLE.
REQ-016 In EXP4/EXP2/EXP1, an unexpected code (including 0 and non-one-hot) SHALL pulse frame_err and leave disp unchanged.
REQ-017 After REQ-016, if the unexpected code is 8, SHALL store shadow3 and go to EXP4 (restart); otherwise SHALL go to IDLE.
REQ-018 frame_valid and frame_err SHALL be registered, asserted in the cycle after the triggering sample, and never both high.
REQ-019 disp SHALL change only on a complete frame; a partial or aborted frame never alters the displayed value.
REQ-020 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick is high on the cycle count==REFRESH_DIV-1.
REQ-021 A 2-bit scan index idx SHALL increment on each tick and wrap 3->0.
REQ-022 an and seg SHALL be registered every cycle from the current idx and disp (one-cycle latency), with an=~(4'b0001<<idx).
REQ-023 Decode SHALL be (hex, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10; values A-F SHALL drive blank=7F.
REQ-024 When BLANK_LZ=1, a position i in 3..1 SHALL drive seg=7F when disp digits i..3 are all zero; pos0 is never blanked.
REQ-025 Frame capture and scanning SHALL be independent; a commit mid-scan takes effect at the next output register update.

Reset
REQ-026 When rst=0 at a clk edge, SHALL set: FSM=IDLE, shadows=0, disp=0, prescaler=0, idx=0, an=4'hF, seg=7'h7F, frame_valid=0, frame_err=0.
REQ-027 Reset mid-frame SHALL discard captured shadows; after rst=1, the first '1' without a preceding 8,4,2 SHALL pulse frame_err.
REQ-028 In the first cycle after reset release, an=4'hE and seg=7'h40 (digit 0 at pos0).

Verification (REFRESH_DIV=4 unless noted)
REQ-029 Stimulus: frame 8/1, 4/2, 2/3, 1/4 on consecutive cycles. Response: frame_valid pulses once; disp=1234; over 16 cycles an cycles E,D,B,7 with seg 19,30,24,79.
REQ-030 Stimulus: 8/5, 4/6, 0/x, then 2/7, 1/8. Response: frame_err pulses on the 0 and again on the stray 2; disp keeps its prior value; no frame_valid.
REQ-031 Stimulus: 8/1, 4/2, 8/9, 4/8, 2/7, 1/6. Response: one frame_err at the second 8; frame_valid once; disp=9876.
REQ-032 Stimulus: BLANK_LZ=1, frame 0,0,0,7. Response: pos3..pos1 seg=7F; pos0 seg=78. Stimulus: frame 0,0,0,0. Response: pos0 seg=40.
REQ-033 Stimulus: rst=0 asserted in EXP2, then released; then 1/3 sent. Response: all reset values per REQ-026; frame_err pulses on the 1; disp=0000.
REQ-034 Stimulus: frame with C_Digit=A at pos2. Response: frame_valid pulses; pos2 seg=7F; the other positions decode normally.
